// File: rtl/desc_mem_arbiter.sv
// desc_mem_arbiter: two-requester arbiter for a single-port descriptor RAM.
//   Requester A (CPU) and requester B (DMA descriptor fetch) share one RAM
//   port. Grant and RAM drive are combinational from the current requests and
//   registered state. Contested grants alternate (round-robin), and read data
//   returns on the issuing port one cycle after each issued read.
//
// Optional feature macro: DESC_ARB_BURST_EN
//   When defined, a B read with b_burstcount=N (0 treated as 1) issues N
//   consecutive word reads. Both requesters are stalled while the burst runs.
//   When undefined, b_burstcount is ignored and no burst logic is built.
//
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   a_*/b_* address/byteenable/read/write/writedata/burstcount  requests
//   a_*/b_* waitrequest/readdata/readdatavalid                  responses
//   mem_address/byteenable/writedata/chipselect/write/clken     RAM drive
//   mem_readdata                       RAM output, one cycle after a read
module desc_mem_arbiter #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     a_address,
   input  logic [DATA_W/8-1:0]   a_byteenable,
   input  logic                  a_read,
   input  logic                  a_write,
   input  logic [DATA_W-1:0]     a_writedata,
   output logic                  a_waitrequest,
   output logic [DATA_W-1:0]     a_readdata,
   output logic                  a_readdatavalid,
   input  logic [ADDR_W-1:0]     b_address,
   input  logic [DATA_W/8-1:0]   b_byteenable,
   input  logic                  b_read,
   input  logic                  b_write,
   input  logic [DATA_W-1:0]     b_writedata,
   input  logic [3:0]            b_burstcount,
   output logic                  b_waitrequest,
   output logic [DATA_W-1:0]     b_readdata,
   output logic                  b_readdatavalid,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic                  mem_clken,
   input  logic [DATA_W-1:0]     mem_readdata
);

   localparam int unsigned BE_W = DATA_W / 8;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;

   logic [0:0]        state_q, state_d;
   logic              favour_b_q, favour_b_d;   // 0: A wins next contest
   logic [ADDR_W-1:0] addr_q, addr_d;           // last driven RAM address
   logic              a_rvalid_q, a_rvalid_d;
   logic              b_rvalid_q, b_rvalid_d;
   logic              a_req, b_req, grant_a, grant_b;

`ifdef DESC_ARB_BURST_EN
   logic [3:0]        beats_q, beats_d;         // beats still to issue
   logic [ADDR_W-1:0] baddr_q, baddr_d;         // next burst address
`else
   logic              unused_burstcount;
   assign unused_burstcount = ^b_burstcount;
`endif

   assign a_req = a_read | a_write;
   assign b_req = b_read | b_write;

   assign a_waitrequest   = ~grant_a;
   assign b_waitrequest   = ~grant_b;
   assign a_readdatavalid = a_rvalid_q;
   assign b_readdatavalid = b_rvalid_q;
   assign a_readdata      = a_rvalid_q ? mem_readdata : '0;
   assign b_readdata      = b_rvalid_q ? mem_readdata : '0;
   assign mem_clken       = 1'b1;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         favour_b_q <= 1'b0;
         addr_q     <= '0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
`ifdef DESC_ARB_BURST_EN
         beats_q    <= '0;
         baddr_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         favour_b_q <= favour_b_d;
         addr_q     <= addr_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
`ifdef DESC_ARB_BURST_EN
         beats_q    <= beats_d;
         baddr_q    <= baddr_d;
`endif
      end
   end

   // Grant decision, RAM drive and next state
   always_comb begin
      state_d        = state_q;
      favour_b_d     = favour_b_q;
      addr_d         = addr_q;
      a_rvalid_d     = 1'b0;
      b_rvalid_d     = 1'b0;
      grant_a        = 1'b0;
      grant_b        = 1'b0;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_address    = addr_q;
      mem_byteenable = '1;
      mem_writedata  = '0;
`ifdef DESC_ARB_BURST_EN
      beats_d        = beats_q;
      baddr_d        = baddr_q;
`endif

      if (!reset_n) begin
         // Nothing is granted while reset is held.
      end else if (state_q == BURST) begin
`ifdef DESC_ARB_BURST_EN
         mem_chipselect = 1'b1;
         mem_address    = baddr_q;
         addr_d         = baddr_q;
         b_rvalid_d     = 1'b1;
         baddr_d        = baddr_q + ADDR_W'(1);
         beats_d        = beats_q - 4'd1;
         if (beats_q == 4'd1) state_d = IDLE;
`else
         state_d = IDLE;
`endif
      end else begin
         if (a_req && b_req) begin
            grant_a    = ~favour_b_q;
            grant_b    = favour_b_q;
            favour_b_d = ~favour_b_q;
         end else begin
            grant_a = a_req;
            grant_b = b_req;
         end

         // Write takes priority when read and write are both asserted.
         if (grant_a) begin
            mem_chipselect = 1'b1;
            mem_write      = a_write;
            mem_address    = a_address;
            addr_d         = a_address;
            if (a_write) begin
               mem_byteenable = a_byteenable;
               mem_writedata  = a_writedata;
            end else begin
               a_rvalid_d = 1'b1;
            end
         end else if (grant_b) begin
            mem_chipselect = 1'b1;
            mem_write      = b_write;
            mem_address    = b_address;
            addr_d         = b_address;
            if (b_write) begin
               mem_byteenable = b_byteenable;
               mem_writedata  = b_writedata;
            end else begin
               b_rvalid_d = 1'b1;
`ifdef DESC_ARB_BURST_EN
               // First beat issues now; the rest run from BURST.
               if (b_burstcount > 4'd1) begin
                  state_d    = BURST;
                  beats_d    = b_burstcount - 4'd1;
                  baddr_d    = b_address + ADDR_W'(1);
                  favour_b_d = 1'b0;
               end
`endif
            end
         end
      end
   end

   logic [BE_W-1:0] unused_be_w;
   assign unused_be_w = '0;

endmodule
